// File: rtl/music_pkg.sv
// Shared types and constants for the melody playback path.
// Used by note_player and its tone oscillator.
package music_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PLAY    = 3'd2,
    GAP     = 3'd3,
    ADVANCE = 3'd4
  } state_e;

  localparam int LOAD_CYCLES = 3;
  localparam int NOTE_AW     = 4;

endpackage

// File: rtl/note_player_if.sv
// Audio sample stream toward the codec.
// master = note_player, slave = codec side.
interface note_player_if;

  logic [31:0] sample;
  logic        sample_valid;
  logic        audio_ready;

  modport master (
    output sample,
    output sample_valid,
    input  audio_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output audio_ready
  );

endinterface

// File: rtl/note_player_square_osc.sv
// Square-wave oscillator: phase counter, polarity, sample mux.
// hp = 0 silences the output and freezes the phase.
module square_osc
  import music_pkg::*;
#(
  parameter logic [31:0] AMPLITUDE = 32'd10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] hp,
  output logic [31:0] sample
);

  logic [31:0] phase;
  logic        pol;

  // >= rather than == so a smaller hp never lets phase run away
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase <= '0;
      pol   <= 1'b0;
    end else if (hp != '0) begin
      if (phase >= hp - 32'd1) begin
        phase <= '0;
        pol   <= ~pol;
      end else begin
        phase <= phase + 32'd1;
      end
    end
  end

  always_comb begin
    sample = '0;
    if (hp != '0)
      sample = pol ? AMPLITUDE : (~AMPLITUDE + 32'd1);
  end

endmodule

// File: rtl/note_player.sv
// Melody sequencer + square-wave tone source feeding the codec.
// Define NOTE_PLAYER_GAP_EN to insert silent GAP_CYCLES between notes.
module note_player
  import music_pkg::*;
#(
  parameter int NUM_NOTES   = 16,
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int AMPLITUDE   = 10_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        half_period,
  note_player_if.master      aud,
  output logic [NOTE_AW-1:0] note_counter,
  output logic               next_note_en,
  output logic               busy,
  output logic               done
);

  localparam int TW = $clog2(NOTE_CYCLES + GAP_CYCLES + 1);

  localparam logic [TW-1:0] T_LATCH = TW'(LOAD_CYCLES - 1);
  // timer spans LOAD entry through ADVANCE, so PLAY ends 2 early
  localparam logic [TW-1:0] T_PLAY_END = TW'(NOTE_CYCLES - 2);
`ifdef NOTE_PLAYER_GAP_EN
  localparam logic [TW-1:0] T_GAP_END =
    TW'(NOTE_CYCLES + GAP_CYCLES - 2);
`endif
  localparam logic [NOTE_AW-1:0] LAST =
    NOTE_AW'(NUM_NOTES - 1);

  state_e        state;
  logic [TW-1:0] timer;
  logic [31:0]   hp_q;
  logic [31:0]   osc_hp;
  logic          osc_clear;
  logic          unused_ready;

  assign busy             = (state != IDLE);
  assign aud.sample_valid = busy;
  assign osc_hp           = (state == PLAY) ? hp_q : '0;
  assign osc_clear        = (state == LOAD);
  assign unused_ready     = aud.audio_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      hp_q         <= '0;
      note_counter <= '0;
      next_note_en <= 1'b0;
      done         <= 1'b0;
    end else begin
      next_note_en <= 1'b0;
      done         <= 1'b0;
      if (stop) begin
        state        <= IDLE;
        timer        <= '0;
        note_counter <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state        <= LOAD;
              timer        <= '0;
              note_counter <= '0;
              next_note_en <= 1'b1;
            end
          end
          LOAD: begin
            timer <= timer + 1'b1;
            if (timer == T_LATCH) begin
              hp_q  <= half_period;
              state <= PLAY;
            end
          end
          PLAY: begin
            timer <= timer + 1'b1;
            if (timer == T_PLAY_END)
`ifdef NOTE_PLAYER_GAP_EN
              state <= GAP;
`else
              state <= ADVANCE;
`endif
          end
`ifdef NOTE_PLAYER_GAP_EN
          GAP: begin
            timer <= timer + 1'b1;
            if (timer == T_GAP_END)
              state <= ADVANCE;
          end
`endif
          ADVANCE: begin
            timer <= '0;
            if (note_counter == LAST) begin
              done         <= 1'b1;
              note_counter <= '0;
              state        <= IDLE;
            end else begin
              note_counter <= note_counter + 1'b1;
              next_note_en <= 1'b1;
              state        <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  square_osc #(
    .AMPLITUDE (32'(AMPLITUDE))
  ) u_osc (
    .clk    (clk),
    .reset  (reset),
    .clear  (osc_clear),
    .hp     (osc_hp),
    .sample (aud.sample)
  );

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player against a per-cycle timeline model.
// Build with +define+NOTE_PLAYER_GAP_EN to exercise the gap variant.
module tb_note_player;

  localparam int NUM = 4;
  localparam int NC  = 20;
  localparam int GC  = 5;
  localparam int AMP = 10_000_000;
`ifdef NOTE_PLAYER_GAP_EN
  localparam int G = GC;
`else
  localparam int G = 0;
`endif
  localparam int L     = NC + G;
  localparam int ACT   = NUM * L;
  localparam int END_K = ACT + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] half_period = '0;
  logic [3:0]  note_counter;
  logic        next_note_en;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int hp_tab[NUM];

  note_player_if aud ();

  note_player #(
    .NUM_NOTES   (NUM),
    .NOTE_CYCLES (NC),
    .GAP_CYCLES  (GC),
    .AMPLITUDE   (AMP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .half_period  (half_period),
    .aud          (aud),
    .note_counter (note_counter),
    .next_note_en (next_note_en),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // tone in PLAY: runs of hp cycles, first run negative
  function automatic int exp_sample(input int hp, input int p);
    if (hp == 0) return 0;
    return ((p / hp) % 2 == 1) ? AMP : -AMP;
  endfunction

  task automatic chk(input string tag, input int k,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s@%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic chk_idle(input int k);
    chk("busy", k, 32'(busy), 32'd0);
    chk("valid", k, 32'(aud.sample_valid), 32'd0);
    chk("sample", k, aud.sample, 32'd0);
    chk("note", k, 32'(note_counter), 32'd0);
    chk("nnen", k, 32'(next_note_en), 32'd0);
    chk("done", k, 32'(done), 32'd0);
  endtask

  // start at cycle 0, model every cycle; abort_k>0 stops/resets there
  task automatic run(input int abort_k, input bit use_reset,
                     input bit rdy_low);
    int  last_k;
    int  n;
    int  o;
    bit  live;
    int  es;
    last_k = (abort_k > 0) ? abort_k + 3 : END_K + 2;
    @(negedge clk);
    start = 1'b1;
    stop = 1'b0;
    half_period = $urandom;
    aud.audio_ready = rdy_low ? 1'b0 : 1'($urandom_range(0, 1));
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      n = (k - 1) / L;
      o = (k - 1) % L;
      live = (k <= ACT) && !(abort_k > 0 && k > abort_k);
      es = 0;
      if (live && o >= 3 && o <= NC - 2)
        es = exp_sample(hp_tab[n], o - 3);
      chk("busy", k, 32'(busy), 32'(live));
      chk("valid", k, 32'(aud.sample_valid), 32'(live));
      chk("sample", k, aud.sample, 32'(es));
      chk("note", k, 32'(note_counter), live ? 32'(n) : 32'd0);
      chk("nnen", k, 32'(next_note_en), 32'(live && o == 0));
      chk("done", k, 32'(done),
          32'(abort_k == 0 && k == END_K));
      if (k <= ACT && (abort_k == 0 || k <= abort_k))
        start = ($urandom_range(0, 3) == 0);
      else
        start = 1'b0;
      half_period = (live && o == 2) ? 32'(hp_tab[n]) : $urandom;
      stop  = !use_reset && (k == abort_k);
      reset = use_reset && (k == abort_k);
      aud.audio_ready = rdy_low ? 1'b0 : 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    aud.audio_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle(0);
    reset = 1'b0;
    @(negedge clk);
    chk_idle(0);

    // full run: hp=3 first, then 1 (toggle every cycle), rest, 2
    hp_tab[0] = 3;
    hp_tab[1] = 1;
    hp_tab[2] = 0;
    hp_tab[3] = 2;
    run(0, 1'b0, 1'b0);

    // codec never ready: tempo must not change
    for (int i = 0; i < NUM; i++) hp_tab[i] = $urandom_range(0, 5);
    run(0, 1'b0, 1'b1);

    // stop mid-note of a silent slot
    for (int i = 0; i < NUM; i++) hp_tab[i] = $urandom_range(1, 4);
    hp_tab[1] = 0;
    run(L + 9, 1'b0, 1'b0);

    // reset while in PLAY
    for (int i = 0; i < NUM; i++) hp_tab[i] = $urandom_range(1, 4);
    run(10, 1'b1, 1'b0);

    // random-tone full run after reset
    for (int i = 0; i < NUM; i++) hp_tab[i] = $urandom_range(0, 7);
    run(0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
